pipe_controller: RTL and testbench

Pipelined control unit for the 5-stage MIPS core. It decodes Opcode/Funct in the Decode stage and resolves branch and jump in Decode. It carries the per-instruction control word through the D→E→M→W pipeline registers so that each control reaches the datapath in its consuming stage. It also exports E/M stage control bits to the hazard unit and keeps a retired-instruction counter for bring-up.

---
 rtl/mips_ctrl_pkg.sv | 61 ++++++
 rtl/alu_decoder.sv | 43 ++++
 rtl/pipe_controller.sv | 182 ++++++++++++++++++
 tb/tb_pipe_controller.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the pipelined MIPS control unit.
// Contents: opcode/funct constants, ALUOp encoding, ALU control codes, and
// the per-stage control word structs carried down the pipeline.
package mips_ctrl_pkg;

  // Primary opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct field (instruction[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Main decoder -> ALU decoder operation class
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // ALU operation codes seen by the datapath
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // E-stage control word (the ALU code travels alongside, its width is a
  // parameter of the top so it is kept out of the struct)
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic alu_src;
    logic reg_dst;
    logic valid;
  } ctrl_e_t;

  // M-stage control word
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic valid;
  } ctrl_m_t;

  // W-stage control word
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic valid;
  } ctrl_w_t;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps ALUOp class and R-type funct to the ALU operation code.
// Ports: alu_op_i/funct_i in; alu_ctrl_o code out, funct_illegal_o set for an
// unknown funct on an R-type (ALUOp=10) instruction. Purely combinational.
module alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int ALUC_W = 3
) (
  input  alu_op_e           alu_op_i,
  input  logic [5:0]        funct_i,
  output logic [ALUC_W-1:0] alu_ctrl_o,
  output logic              funct_illegal_o
);

  logic [2:0] code;

  always_comb begin
    code            = ALU_ADD;
    funct_illegal_o = 1'b0;
    case (alu_op_i)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  code = ALU_ADD;
          FN_SUB:  code = ALU_SUB;
          FN_AND:  code = ALU_AND;
          FN_OR:   code = ALU_OR;
          FN_SLT:  code = ALU_SLT;
          default: begin
            code            = ALU_AND;
            funct_illegal_o = 1'b1;
          end
        endcase
      end
      // Unused encoding: the main decoder never produces it
      default: code = ALU_ADD;
    endcase
  end

  assign alu_ctrl_o = ALUC_W'(code);

endmodule

// File: rtl/pipe_controller.sv
// Pipelined control unit: decodes Opcode/Funct in D, resolves branch/jump in D,
// and carries the control word through D->E->M->W registers (E=+1, M=+2, W=+3).
// Ports: D-stage decode in, per-stage controls out, hazard-unit taps, retired count.
module pipe_controller
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int ALUC_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        Opcode,
  input  logic [5:0]        Funct,
  input  logic              branch_boolean,
  input  logic              FlushE,
  output logic              PCSrc,
  output logic              JumpC,
  output logic              BranchD,
  output logic              RegDstE,
  output logic              ALUSrcB,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic              RegWriteE,
  output logic              MemToRegE,
  output logic              RegWriteM,
  output logic              MemToRegM,
  output logic              MemWrite,
  output logic              RegWriteW,
  output logic              MemToReg,
  output logic              illegal_d,
  output logic [CNT_W-1:0]  retired_count
);

  // ---------------------------------------------------------------- D stage
  logic    reg_write_dec, mem_to_reg_dec, mem_write_dec;
  logic    alu_src_dec, reg_dst_dec, branch_dec, jump_dec, op_known;
  alu_op_e alu_op_dec;

  always_comb begin
    reg_write_dec  = 1'b0;
    mem_to_reg_dec = 1'b0;
    mem_write_dec  = 1'b0;
    alu_src_dec    = 1'b0;
    reg_dst_dec    = 1'b0;
    branch_dec     = 1'b0;
    jump_dec       = 1'b0;
    op_known       = 1'b1;
    alu_op_dec     = ALUOP_ADD;
    case (Opcode)
      OP_RTYPE: begin
        reg_write_dec = 1'b1;
        reg_dst_dec   = 1'b1;
        alu_op_dec    = ALUOP_FUNCT;
      end
      OP_LW: begin
        reg_write_dec  = 1'b1;
        alu_src_dec    = 1'b1;
        mem_to_reg_dec = 1'b1;
      end
      OP_SW: begin
        mem_write_dec = 1'b1;
        alu_src_dec   = 1'b1;
      end
      OP_BEQ: begin
        branch_dec = 1'b1;
        alu_op_dec = ALUOP_SUB;
      end
      OP_ADDI: begin
        reg_write_dec = 1'b1;
        alu_src_dec   = 1'b1;
      end
      OP_J:    jump_dec = 1'b1;
      default: op_known = 1'b0;
    endcase
  end

  logic [ALUC_W-1:0] alu_ctrl_dec;
  logic              funct_illegal;

  alu_decoder #(.ALUC_W(ALUC_W)) u_alu_decoder (
    .alu_op_i        (alu_op_dec),
    .funct_i         (Funct),
    .alu_ctrl_o      (alu_ctrl_dec),
    .funct_illegal_o (funct_illegal)
  );

  // An unknown instruction becomes a full nop so nothing downstream acts on it
  assign illegal_d = !op_known || funct_illegal;

  assign BranchD = branch_dec && !illegal_d;
  assign JumpC   = jump_dec && !illegal_d;
  // Resolved in D; deliberately independent of FlushE
  assign PCSrc   = BranchD && branch_boolean;

  ctrl_e_t           ctrl_e_d, ctrl_e_q;
  logic [ALUC_W-1:0] aluc_e_d, aluc_e_q;

  always_comb begin
    ctrl_e_d = '0;
    aluc_e_d = '0;
    if (!illegal_d) begin
      ctrl_e_d.reg_write  = reg_write_dec;
      ctrl_e_d.mem_to_reg = mem_to_reg_dec;
      ctrl_e_d.mem_write  = mem_write_dec;
      ctrl_e_d.alu_src    = alu_src_dec;
      ctrl_e_d.reg_dst    = reg_dst_dec;
      ctrl_e_d.valid      = 1'b1;
      aluc_e_d            = alu_ctrl_dec;
    end
  end

  // ---------------------------------------------------------------- E stage
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      ctrl_e_q <= '0;
      aluc_e_q <= '0;
    end else begin
      ctrl_e_q <= ctrl_e_d;
      aluc_e_q <= aluc_e_d;
    end
  end

  assign RegDstE     = ctrl_e_q.reg_dst;
  assign ALUSrcB     = ctrl_e_q.alu_src;
  assign ALUControlE = aluc_e_q;
  assign RegWriteE   = ctrl_e_q.reg_write;
  assign MemToRegE   = ctrl_e_q.mem_to_reg;

  // ---------------------------------------------------------------- M stage
  ctrl_m_t ctrl_m_d, ctrl_m_q;

  always_comb begin
    ctrl_m_d            = '0;
    ctrl_m_d.reg_write  = ctrl_e_q.reg_write;
    ctrl_m_d.mem_to_reg = ctrl_e_q.mem_to_reg;
    ctrl_m_d.mem_write  = ctrl_e_q.mem_write;
    ctrl_m_d.valid      = ctrl_e_q.valid;
  end

  always_ff @(posedge clk) begin
    if (reset) ctrl_m_q <= '0;
    else       ctrl_m_q <= ctrl_m_d;
  end

  assign RegWriteM = ctrl_m_q.reg_write;
  assign MemToRegM = ctrl_m_q.mem_to_reg;
  assign MemWrite  = ctrl_m_q.mem_write;

  // ---------------------------------------------------------------- W stage
  ctrl_w_t ctrl_w_d, ctrl_w_q;

  always_comb begin
    ctrl_w_d            = '0;
    ctrl_w_d.reg_write  = ctrl_m_q.reg_write;
    ctrl_w_d.mem_to_reg = ctrl_m_q.mem_to_reg;
    ctrl_w_d.valid      = ctrl_m_q.valid;
  end

  always_ff @(posedge clk) begin
    if (reset) ctrl_w_q <= '0;
    else       ctrl_w_q <= ctrl_w_d;
  end

  assign RegWriteW = ctrl_w_q.reg_write;
  assign MemToReg  = ctrl_w_q.mem_to_reg;

  // ------------------------------------------------------- retired counter
  // Counts each edge with a valid instruction in W; wraps naturally.
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (ctrl_w_q.valid) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign retired_count = cnt_q;

endmodule

// File: tb/tb_pipe_controller.sv
module tb_pipe_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode, Funct;
  logic       branch_boolean, FlushE;
  logic       PCSrc, JumpC, BranchD, RegDstE, ALUSrcB;
  logic [2:0] ALUControlE;
  logic       RegWriteE, MemToRegE, RegWriteM, MemToRegM, MemWrite;
  logic       RegWriteW, MemToReg, illegal_d;
  logic [15:0] retired_count;

  always #5 clk = ~clk;

  pipe_controller #(.CNT_W(16), .ALUC_W(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .Opcode         (Opcode),
    .Funct          (Funct),
    .branch_boolean (branch_boolean),
    .FlushE         (FlushE),
    .PCSrc          (PCSrc),
    .JumpC          (JumpC),
    .BranchD        (BranchD),
    .RegDstE        (RegDstE),
    .ALUSrcB        (ALUSrcB),
    .ALUControlE    (ALUControlE),
    .RegWriteE      (RegWriteE),
    .MemToRegE      (MemToRegE),
    .RegWriteM      (RegWriteM),
    .MemToRegM      (MemToRegM),
    .MemWrite       (MemWrite),
    .RegWriteW      (RegWriteW),
    .MemToReg       (MemToReg),
    .illegal_d      (illegal_d),
    .retired_count  (retired_count)
  );

  // Expected control word of one instruction as it leaves D
  typedef struct packed {
    logic       rw;
    logic       m2r;
    logic       mw;
    logic [2:0] aluc;
    logic       asrc;
    logic       rdst;
    logic       valid;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;
  bit quiet    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode written straight from the instruction table
  function automatic exp_t ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                      output logic illegal);
    exp_t e;
    e = '0;
    illegal = 1'b0;
    case (op)
      6'b000000: begin
        e.rw = 1; e.rdst = 1;
        case (fn)
          6'b100000: e.aluc = 3'b010;
          6'b100010: e.aluc = 3'b110;
          6'b100100: e.aluc = 3'b000;
          6'b100101: e.aluc = 3'b001;
          6'b101010: e.aluc = 3'b111;
          default:   illegal = 1;
        endcase
      end
      6'b100011: begin e.rw = 1; e.asrc = 1; e.m2r = 1; e.aluc = 3'b010; end
      6'b101011: begin e.mw = 1; e.asrc = 1; e.aluc = 3'b010; end
      6'b000100: e.aluc = 3'b110;
      6'b001000: begin e.rw = 1; e.asrc = 1; e.aluc = 3'b010; end
      6'b000010: e.aluc = 3'b010;
      default:   illegal = 1;
    endcase
    if (illegal) e = '0;
    else e.valid = 1;
    return e;
  endfunction

  exp_t q_e[$];
  exp_t q_m[$];
  exp_t q_w[$];
  logic [15:0] cnt_model = 16'd0;
  logic        w_valid_model = 1'b0;

  // One D-stage instruction per cycle: drive, check D outputs, push the
  // expected E word, clock, then pop and compare each stage.
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic bb,
                      input logic fl, input logic rst);
    exp_t e, em, ew, pe;
    logic ill;
    Opcode = op; Funct = fn; branch_boolean = bb; FlushE = fl; reset = rst;
    #1;
    e = ref_decode(op, fn, ill);
    if (!quiet) begin
      check("illegal_d", illegal_d, ill);
      check("BranchD", BranchD, (!ill && op == 6'b000100));
      check("PCSrc", PCSrc, (!ill && op == 6'b000100 && bb));
      check("JumpC", JumpC, (!ill && op == 6'b000010));
    end
    q_e.push_back((fl || rst) ? exp_t'('0) : e);
    @(posedge clk);
    #1;
    // Counter sees W valid from before the edge
    if (rst) cnt_model = 16'd0;
    else if (w_valid_model) cnt_model = cnt_model + 16'd1;
    pe = q_e.pop_front();
    em = (q_m.size() > 0) ? q_m.pop_front() : exp_t'('0);
    ew = (q_w.size() > 0) ? q_w.pop_front() : exp_t'('0);
    if (rst) begin em = '0; ew = '0; end
    q_m.push_back(pe);
    q_w.push_back(em);
    w_valid_model = ew.valid;
    if (!quiet) begin
      check("RegDstE", RegDstE, pe.rdst);
      check("ALUSrcB", ALUSrcB, pe.asrc);
      check("ALUControlE", ALUControlE, pe.aluc);
      check("RegWriteE", RegWriteE, pe.rw);
      check("MemToRegE", MemToRegE, pe.m2r);
      check("RegWriteM", RegWriteM, em.rw);
      check("MemToRegM", MemToRegM, em.m2r);
      check("MemWrite", MemWrite, em.mw);
      check("RegWriteW", RegWriteW, ew.rw);
      check("MemToRegW", MemToReg, ew.m2r);
      check("retired_count", retired_count, cnt_model);
    end
  endtask

  localparam logic [5:0] NOP_OP = 6'b000000, NOP_FN = 6'b000000;

  initial begin
    logic [15:0] base;
    reset = 1'b1; Opcode = NOP_OP; Funct = NOP_FN; branch_boolean = 0; FlushE = 0;
    #2;

    // Reset 2 cycles, release with illegal nop
    step(NOP_OP, NOP_FN, 0, 0, 1);
    step(NOP_OP, NOP_FN, 0, 0, 1);
    step(NOP_OP, NOP_FN, 0, 0, 0);
    check("reset_count", retired_count, 16'd0);

    // add, lw, sw, beq(not taken), then drain
    step(6'b000000, 6'b100000, 0, 0, 0);
    step(6'b100011, 6'b000000, 0, 0, 0);
    step(6'b101011, 6'b000000, 0, 0, 0);
    step(6'b000100, 6'b000000, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(NOP_OP, NOP_FN, 0, 0, 0);
    check("stream_count", retired_count, 16'd4);

    // Branch/jump resolution in D
    step(6'b000100, 6'b000000, 1, 0, 0);
    step(6'b000100, 6'b000000, 0, 0, 0);
    step(6'b000010, 6'b000000, 1, 0, 0);

    // Load-use bubble: lw, add flushed, add re-issued
    for (int i = 0; i < 4; i++) step(NOP_OP, NOP_FN, 0, 0, 0);
    base = retired_count;
    step(6'b100011, 6'b000000, 0, 0, 0);
    step(6'b000000, 6'b100000, 0, 1, 0);
    check("bubble_RegWriteE", RegWriteE, 1'b0);
    check("bubble_ALUControlE", ALUControlE, 3'b000);
    step(6'b000000, 6'b100000, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(NOP_OP, NOP_FN, 0, 0, 0);
    check("bubble_count", retired_count, base + 16'd2);

    // R-type funct variants
    step(6'b000000, 6'b101010, 0, 0, 0);
    step(6'b000000, 6'b100101, 0, 0, 0);
    step(6'b000000, 6'b100100, 0, 0, 0);
    step(6'b000000, 6'b100010, 0, 0, 0);
    step(6'b000000, 6'b111111, 0, 0, 0);
    step(6'b111111, 6'b100000, 0, 0, 0);
    step(6'b001000, 6'b000000, 0, 0, 0);

    // Reset while lw in M
    step(6'b100011, 6'b000000, 0, 0, 0);
    step(6'b000000, 6'b100000, 0, 0, 0);
    step(NOP_OP, NOP_FN, 0, 1, 1);
    check("rst_MemToRegM", MemToRegM, 1'b0);
    check("rst_RegWriteW", RegWriteW, 1'b0);
    check("rst_count", retired_count, 16'd0);

    // Run the counter up to all-ones, then retire one more
    quiet = 1'b1;
    for (int i = 0; i < 70000 && cnt_model != 16'hFFFF; i++)
      step(6'b001000, 6'b000000, 0, 0, 0);
    quiet = 1'b0;
    check("count_full", retired_count, 16'hFFFF);
    step(6'b001000, 6'b000000, 0, 0, 0);
    check("count_wrap", retired_count, 16'h0000);
    for (int i = 0; i < 3; i++) step(NOP_OP, NOP_FN, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
